// File: rtl/wash_cycle_timer.sv
// rtl/wash_cycle_timer.sv - prescaled wash/spin phase timer with level TIMER_DONE.
// Optional door-open freeze is compiled in with `define WASH_TIMER_PAUSE_EN.
module wash_cycle_timer #(
  parameter int TICK_DIV = 1000,
  parameter int T_DEF    = 10,
  parameter int T_WASH_M = 30,
  parameter int T_WASH_H = 45,
  parameter int T_SPIN   = 20,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIMER_EN,
  input  logic [1:0]       TIMER_SEL,
  input  logic             PAUSE,
  output logic             TIMER_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] REMAIN
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] D_DEF     = CNT_W'(T_DEF);
  localparam logic [CNT_W-1:0] D_WASH_M  = CNT_W'(T_WASH_M);
  localparam logic [CNT_W-1:0] D_WASH_H  = CNT_W'(T_WASH_H);
  localparam logic [CNT_W-1:0] D_SPIN    = CNT_W'(T_SPIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [CNT_W-1:0] remain_n;
  logic [1:0]       sel_q, sel_n;
  logic [CNT_W-1:0] start_dur;
  logic             hold;

`ifdef WASH_TIMER_PAUSE_EN
  assign hold = PAUSE;
`else
  logic pause_unused;
  assign pause_unused = PAUSE;
  assign hold = 1'b0;
`endif

  always_comb begin
    start_dur = D_DEF;
    case (TIMER_SEL)
      2'b01:   start_dur = D_WASH_M;
      2'b10:   start_dur = D_WASH_H;
      2'b11:   start_dur = D_SPIN;
      default: start_dur = D_DEF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      presc      <= '0;
      REMAIN     <= '0;
      sel_q      <= 2'b00;
      TIMER_DONE <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      REMAIN     <= remain_n;
      sel_q      <= sel_n;
      TIMER_DONE <= (state_n == EXPIRED);
      BUSY       <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    remain_n = REMAIN;
    sel_n    = sel_q;
    case (state)
      IDLE: begin
        if (TIMER_EN) begin
          sel_n    = TIMER_SEL;
          remain_n = start_dur;
          presc_n  = '0;
          state_n  = (start_dur == '0) ? EXPIRED : RUN;
        end
      end
      RUN: begin
        // Abort outranks both the tick and a pending pause.
        if (!TIMER_EN) begin
          state_n  = IDLE;
          remain_n = '0;
          presc_n  = '0;
        end else if (!hold) begin
          if (presc == PRESC_MAX) begin
            presc_n  = '0;
            remain_n = REMAIN - 1'b1;
            if (REMAIN == CNT_W'(1)) state_n = EXPIRED;
          end else begin
            presc_n = presc + 1'b1;
          end
        end
      end
      EXPIRED: begin
        remain_n = '0;
        if (!TIMER_EN) state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        remain_n = '0;
        presc_n  = '0;
      end
    endcase
  end

endmodule
